// File: rtl/pe_stream_loader_if.sv
// Stream beat input and PE buffer write bus for pe_stream_loader.
// The master drives stream beats and write readiness; the slave is the loader.
interface pe_stream_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              src_valid;
  logic              src_is_filter;
  logic              src_last;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;
  logic              wr_ready;
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output src_valid, src_is_filter, src_last, src_data, wr_ready,
    input  src_ready, wr_en, wr_sel, wr_addr, wr_data
  );

  modport slave (
    input  src_valid, src_is_filter, src_last, src_data, wr_ready,
    output src_ready, wr_en, wr_sel, wr_addr, wr_data
  );
endinterface

// File: rtl/pe_stream_loader.sv
// Routes tagged stream beats into the PE filter/input buffers and signals load completion.
// One load FSM per target; the filter finish is a level and the input finish is a pulse.
module pe_stream_loader_fsm #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 7,
  parameter bit PULSE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [CNT_W-1:0] len,
  input  logic             acc,
  input  logic             last,
  output logic             active,
  output logic [CNT_W-1:0] cnt,
  output logic             finish,
  output logic             err
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

  state_e           state;
  logic [CNT_W-1:0] len_q;
  logic             req_q;
  logic             start, clamp, fin_beat, done;

  assign clamp    = len > CNT_W'(DEPTH);
  // From DONE only a rising request edge starts the next load.
  assign start    = ((state == S_IDLE) && req) || ((state == S_DONE) && req && !req_q);
  assign fin_beat = cnt == (len_q - CNT_W'(1));
  assign done     = (state == S_LOAD) && ((len_q == '0) || (acc && (fin_beat || last)));
  // A zero-length load never accepts beats so it cannot produce writes.
  assign active   = (state == S_LOAD) && (len_q != '0);
  assign err      = (start && clamp) || (acc && (fin_beat != last));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      len_q  <= '0;
      cnt    <= '0;
      finish <= 1'b0;
      req_q  <= 1'b0;
    end else begin
      req_q <= req;
      if (PULSE) finish <= 1'b0;
      if (start) begin
        state  <= S_LOAD;
        len_q  <= clamp ? CNT_W'(DEPTH) : len;
        cnt    <= '0;
        finish <= 1'b0;
      end else if (state == S_LOAD) begin
        if (acc) cnt <= cnt + CNT_W'(1);
        if (done) begin
          state  <= S_DONE;
          finish <= 1'b1;
        end
      end
    end
  end
endmodule

module pe_stream_loader #(
  parameter int DATA_W       = 16,
  parameter int FILTER_DEPTH = 64,
  parameter int INPUT_DEPTH  = 256,
  parameter int FCNT_W       = $clog2(FILTER_DEPTH+1),
  parameter int ICNT_W       = $clog2(INPUT_DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_filter_valid,
  input  logic              req_input_valid,
  input  logic [FCNT_W-1:0] filter_len,
  input  logic [ICNT_W-1:0] input_len,
  pe_stream_loader_if.slave bus,
  output logic              stream_filter_finish,
  output logic              stream_input_finish,
  output logic              err_len
);
  localparam int AW = $clog2(INPUT_DEPTH);

  logic              f_active, i_active, f_acc, i_acc, f_err, i_err;
  logic [FCNT_W-1:0] fcnt;
  logic [ICNT_W-1:0] icnt;

  assign bus.src_ready = bus.wr_ready & bus.src_valid & (bus.src_is_filter ? f_active : i_active);
  assign f_acc = bus.src_ready & bus.src_is_filter;
  assign i_acc = bus.src_ready & ~bus.src_is_filter;

  pe_stream_loader_fsm #(.DEPTH(FILTER_DEPTH), .CNT_W(FCNT_W), .PULSE(1'b0)) u_filter (
    .clk(clk), .rst(rst), .req(req_filter_valid), .len(filter_len), .acc(f_acc),
    .last(bus.src_last), .active(f_active), .cnt(fcnt), .finish(stream_filter_finish),
    .err(f_err)
  );

  pe_stream_loader_fsm #(.DEPTH(INPUT_DEPTH), .CNT_W(ICNT_W), .PULSE(1'b1)) u_input (
    .clk(clk), .rst(rst), .req(req_input_valid), .len(input_len), .acc(i_acc),
    .last(bus.src_last), .active(i_active), .cnt(icnt), .finish(stream_input_finish),
    .err(i_err)
  );

  // Write stage lands together with the finish flag raised on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.wr_en   <= 1'b0;
      bus.wr_sel  <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      err_len     <= 1'b0;
    end else begin
      bus.wr_en <= f_acc | i_acc;
      if (f_acc | i_acc) begin
        bus.wr_sel  <= bus.src_is_filter;
        bus.wr_data <= bus.src_data;
        bus.wr_addr <= bus.src_is_filter ? AW'(fcnt) : AW'(icnt);
      end
      if (f_err | i_err) err_len <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pe_stream_loader.sv
// Directed table-driven bench for pe_stream_loader plus an async-reset sequence.
module tb_pe_stream_loader;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_filter_valid, req_input_valid;
  logic [6:0] filter_len;
  logic [8:0] input_len;
  logic       stream_filter_finish, stream_input_finish, err_len;
  int         ntests = 0;
  int         nfail = 0;

  pe_stream_loader_if #(.DATA_W(16), .ADDR_W(8)) bus();

  pe_stream_loader dut (
    .clk(clk), .rst(rst), .req_filter_valid(req_filter_valid),
    .req_input_valid(req_input_valid), .filter_len(filter_len), .input_len(input_len),
    .bus(bus), .stream_filter_finish(stream_filter_finish),
    .stream_input_finish(stream_input_finish), .err_len(err_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rs, rf, ri, fl, il, vl, tf, lst, d, wr;
    int er, ew, es, ea, ed, eff, eif, eer;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int rs, int rf, int ri, int fl, int il, int vl, int tf, int lst,
                              int d, int wr, int er, int ew, int es, int ea, int ed,
                              int eff, int eif, int eer);
    vec_t v;
    v.rs = rs; v.rf = rf; v.ri = ri; v.fl = fl; v.il = il; v.vl = vl; v.tf = tf;
    v.lst = lst; v.d = d; v.wr = wr; v.er = er; v.ew = ew; v.es = es; v.ea = ea;
    v.ed = ed; v.eff = eff; v.eif = eif; v.eer = eer;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic do_reset(input int idx);
    rst = 1'b0;
    req_filter_valid = 0; req_input_valid = 0; filter_len = 0; input_len = 0;
    bus.src_valid = 0; bus.src_is_filter = 0; bus.src_last = 0; bus.src_data = 0;
    bus.wr_ready = 0;
    #1;
    chk("rst_wr_en", idx, bus.wr_en, 0);
    chk("rst_ffin", idx, stream_filter_finish, 0);
    chk("rst_ifin", idx, stream_input_finish, 0);
    chk("rst_err", idx, err_len, 0);
    chk("rst_addr", idx, bus.wr_addr, 0);
    rst = 1'b1;
  endtask

  initial begin
    // filter load of 5, then a level request held in DONE
    vecs.push_back(mk(1,1,0,5,0, 0,0,0,0,1,       0,0,0,0,0,        0,0,0));
    vecs.push_back(mk(0,1,0,5,0, 1,1,0,'hA000,1,  1,1,1,0,'hA000,   0,0,0));
    vecs.push_back(mk(0,1,0,5,0, 1,1,0,'hA001,1,  1,1,1,1,'hA001,   0,0,0));
    vecs.push_back(mk(0,1,0,5,0, 1,1,0,'hA002,1,  1,1,1,2,'hA002,   0,0,0));
    vecs.push_back(mk(0,1,0,5,0, 1,1,0,'hA003,1,  1,1,1,3,'hA003,   0,0,0));
    vecs.push_back(mk(0,1,0,5,0, 1,1,1,'hA004,1,  1,1,1,4,'hA004,   1,0,0));
    vecs.push_back(mk(0,1,0,5,0, 0,0,0,0,1,       0,0,0,0,0,        1,0,0));
    vecs.push_back(mk(0,1,0,5,0, 1,1,0,'hA005,1,  0,0,0,0,0,        1,0,0));
    // concurrent filter 3 / input 4, beats F,I,F,I,I,F,I
    vecs.push_back(mk(1,1,1,3,4, 0,0,0,0,1,       0,0,0,0,0,        0,0,0));
    vecs.push_back(mk(0,1,1,3,4, 1,1,0,'hB000,1,  1,1,1,0,'hB000,   0,0,0));
    vecs.push_back(mk(0,1,1,3,4, 1,0,0,'hC000,1,  1,1,0,0,'hC000,   0,0,0));
    vecs.push_back(mk(0,1,1,3,4, 1,1,0,'hB001,1,  1,1,1,1,'hB001,   0,0,0));
    vecs.push_back(mk(0,1,1,3,4, 1,0,0,'hC001,1,  1,1,0,1,'hC001,   0,0,0));
    vecs.push_back(mk(0,1,1,3,4, 1,0,0,'hC002,1,  1,1,0,2,'hC002,   0,0,0));
    vecs.push_back(mk(0,1,1,3,4, 1,1,1,'hB002,1,  1,1,1,2,'hB002,   1,0,0));
    vecs.push_back(mk(0,1,1,3,4, 1,0,1,'hC003,1,  1,1,0,3,'hC003,   1,1,0));
    vecs.push_back(mk(0,1,1,3,4, 0,0,0,0,1,       0,0,0,0,0,        1,0,0));
    // backpressure during a filter load of 4
    vecs.push_back(mk(1,1,0,4,0, 0,0,0,0,1,       0,0,0,0,0,        0,0,0));
    vecs.push_back(mk(0,1,0,4,0, 1,1,0,'hD000,1,  1,1,1,0,'hD000,   0,0,0));
    vecs.push_back(mk(0,1,0,4,0, 1,1,0,'hD001,1,  1,1,1,1,'hD001,   0,0,0));
    vecs.push_back(mk(0,1,0,4,0, 1,1,0,'hD002,0,  0,0,0,0,0,        0,0,0));
    vecs.push_back(mk(0,1,0,4,0, 1,1,0,'hD002,0,  0,0,0,0,0,        0,0,0));
    vecs.push_back(mk(0,1,0,4,0, 1,1,0,'hD002,0,  0,0,0,0,0,        0,0,0));
    vecs.push_back(mk(0,1,0,4,0, 1,1,0,'hD002,1,  1,1,1,2,'hD002,   0,0,0));
    vecs.push_back(mk(0,1,0,4,0, 1,1,1,'hD003,1,  1,1,1,3,'hD003,   1,0,0));
    // next-k: drop request one cycle, re-raise with length 2
    vecs.push_back(mk(0,0,0,2,0, 0,0,0,0,1,       0,0,0,0,0,        1,0,0));
    vecs.push_back(mk(0,1,0,2,0, 0,0,0,0,1,       0,0,0,0,0,        0,0,0));
    vecs.push_back(mk(0,1,0,2,0, 1,1,0,'hE000,1,  1,1,1,0,'hE000,   0,0,0));
    vecs.push_back(mk(0,1,0,2,0, 1,1,1,'hE001,1,  1,1,1,1,'hE001,   1,0,0));
    vecs.push_back(mk(0,1,0,2,0, 0,0,0,0,1,       0,0,0,0,0,        1,0,0));
    vecs.push_back(mk(0,1,0,2,0, 1,1,0,'hE002,1,  0,0,0,0,0,        1,0,0));
    // early src_last, then an input beat stalled while input is idle
    vecs.push_back(mk(1,1,0,4,0, 0,0,0,0,1,       0,0,0,0,0,        0,0,0));
    vecs.push_back(mk(0,1,0,4,0, 1,1,0,'hF000,1,  1,1,1,0,'hF000,   0,0,0));
    vecs.push_back(mk(0,1,0,4,0, 1,1,1,'hF001,1,  1,1,1,1,'hF001,   1,0,1));
    vecs.push_back(mk(0,1,0,4,0, 0,0,0,0,1,       0,0,0,0,0,        1,0,1));
    vecs.push_back(mk(0,1,0,4,1, 1,0,1,'h1234,1,  0,0,0,0,0,        1,0,1));
    vecs.push_back(mk(0,1,0,4,1, 1,0,1,'h1234,1,  0,0,0,0,0,        1,0,1));
    vecs.push_back(mk(0,1,1,4,1, 1,0,1,'h1234,1,  0,0,0,0,0,        1,0,1));
    vecs.push_back(mk(0,1,1,4,1, 1,0,1,'h1234,1,  1,1,0,0,'h1234,   1,1,1));
    vecs.push_back(mk(0,1,1,4,1, 0,0,0,0,1,       0,0,0,0,0,        1,0,1));
    // zero-length loads on both sides
    vecs.push_back(mk(1,1,1,0,0, 0,0,0,0,1,       0,0,0,0,0,        0,0,0));
    vecs.push_back(mk(0,1,1,0,0, 0,0,0,0,1,       0,0,0,0,0,        1,1,0));
    vecs.push_back(mk(0,1,1,0,0, 0,0,0,0,1,       0,0,0,0,0,        1,0,0));
    // over-depth filter length is clamped and flagged
    vecs.push_back(mk(1,1,0,100,0, 0,0,0,0,1,     0,0,0,0,0,        0,0,1));

    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].rs != 0) do_reset(i);
      req_filter_valid  = vecs[i].rf[0];
      req_input_valid   = vecs[i].ri[0];
      filter_len        = 7'(vecs[i].fl);
      input_len         = 9'(vecs[i].il);
      bus.src_valid     = vecs[i].vl[0];
      bus.src_is_filter = vecs[i].tf[0];
      bus.src_last      = vecs[i].lst[0];
      bus.src_data      = 16'(vecs[i].d);
      bus.wr_ready      = vecs[i].wr[0];
      #1;
      chk("src_ready", i, bus.src_ready, vecs[i].er);
      @(posedge clk);
      #1;
      chk("wr_en", i, bus.wr_en, vecs[i].ew);
      if (vecs[i].ew != 0) begin
        chk("wr_sel", i, bus.wr_sel, vecs[i].es);
        chk("wr_addr", i, bus.wr_addr, vecs[i].ea);
        chk("wr_data", i, bus.wr_data, vecs[i].ed);
      end
      chk("filter_finish", i, stream_filter_finish, vecs[i].eff);
      chk("input_finish", i, stream_input_finish, vecs[i].eif);
      chk("err_len", i, err_len, vecs[i].eer);
    end

    // async reset between edges in the middle of a 6-word filter load
    @(negedge clk);
    do_reset(100);
    req_filter_valid = 1; filter_len = 6; bus.wr_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    bus.src_valid = 1; bus.src_is_filter = 1; bus.src_data = 16'h0001;
    @(posedge clk); #1;
    @(negedge clk);
    bus.src_data = 16'h0002;
    @(posedge clk); #1;
    chk("pre_rst_addr", 101, bus.wr_addr, 1);
    chk("pre_rst_wr_en", 101, bus.wr_en, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("async_wr_en", 102, bus.wr_en, 0);
    chk("async_addr", 102, bus.wr_addr, 0);
    chk("async_ready", 102, bus.src_ready, 0);
    chk("async_ffin", 102, stream_filter_finish, 0);
    @(negedge clk);
    rst = 1'b1; bus.src_valid = 0; filter_len = 1;
    @(posedge clk); #1;
    chk("post_rst_no_write", 103, bus.wr_en, 0);
    @(negedge clk);
    bus.src_valid = 1; bus.src_last = 1; bus.src_data = 16'h0007;
    @(posedge clk); #1;
    chk("post_rst_wr_en", 104, bus.wr_en, 1);
    chk("post_rst_addr", 104, bus.wr_addr, 0);
    chk("post_rst_data", 104, bus.wr_data, 16'h0007);
    chk("post_rst_ffin", 104, stream_filter_finish, 1);
    chk("post_rst_err", 104, err_len, 0);
    @(negedge clk);
    bus.src_valid = 0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
